mem_clr_ram: RTL and testbench
==============================

MEM_CLR_RAM -- requirements
Module: mem_clr_ram

Interface
REQ-001 Parameter WIDTH, default 8, the data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 7, the number of entries (2..1024); it does not need to be a power of two.
REQ-003 Parameter AW, default $clog2(DEPTH), the address width.
REQ-004 clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 clr_req  in  1  one-cycle request to zero the whole array.
REQ-007 wr_en  in  1  write strobe.
REQ-008 wr_addr  in  AW  write address.
REQ-009 wr_data  in  WIDTH  write data.
REQ-010 rd_en  in  1  read strobe.
REQ-011 rd_addr  in  AW  read address.
REQ-012 ready  out  1  high when write and read strobes are accepted.
REQ-013 rd_data  out  WIDTH  registered read data.
REQ-014 rd_valid  out  1  qualifies rd_data.
REQ-015 clr_busy  out  1  a clear sequence is in progress.
REQ-016 clr_done  out  1  one-cycle pulse at clear completion.

Function
REQ-017 The FSM SHALL have two states, IDLE and CLEAR; ready = (state == IDLE) and clr_busy = (state == CLEAR).
REQ-018 In IDLE, clr_req SHALL cause a transition to CLEAR with the clear index set to 0.
REQ-019 In CLEAR, the block SHALL write 0 to entry[index] each cycle and increment the index.
REQ-020 When index == DEPTH-1, the block SHALL clear that entry, return to IDLE and assert clr_done for exactly the next cycle; a clear takes exactly DEPTH cycles.
REQ-021 The index SHALL wrap at DEPTH, not at 2**AW; entries at or above DEPTH are never addressed.
REQ-022 clr_req during CLEAR SHALL be ignored; it does not restart, extend or queue a clear.
REQ-023 A write with wr_en && ready SHALL update the entry at the clock edge.
REQ-024 A write with wr_addr >= DEPTH SHALL be discarded.
REQ-025 A write in the same cycle as an accepted clr_req SHALL be performed and then zeroed by the ensuing clear.
REQ-026 A read with rd_en && ready SHALL register mem[rd_addr] into rd_data and set rd_valid=1 on the next cycle (latency 1).
REQ-027 Without a new accepted read, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-028 A read with rd_addr >= DEPTH SHALL return 0 with rd_valid=1.
REQ-029 Write and read strobes while ready=0 SHALL be dropped with no side effects.

Reset
REQ-030 While rst_n=0, the outputs SHALL be: rd_data=0, rd_valid=0, clr_done=0, ready=0, clr_busy=1.
REQ-031 While rst_n=0, the state SHALL be CLEAR with index 0; on release, a full clear runs automatically (DEPTH cycles), then clr_done pulses.
REQ-032 Asserting rst_n mid-clear SHALL abort the clear; the sequence restarts from index 0 after release.
REQ-033 The array itself is not reset asynchronously; only the clear sequence initialises it.

Configuration
REQ-034 Macro MEM_CLR_FWD_EN defined: a read and an accepted write to the same in-range address in the same cycle SHALL return wr_data (write-first).
REQ-035 Macro MEM_CLR_FWD_EN undefined: the same collision SHALL return the entry's previous contents (read-first).

Structure
REQ-036 Package mem_clr_pkg SHALL hold the state enum (IDLE, CLEAR) and the default WIDTH and DEPTH constants.
REQ-037 The FSM and index counter SHALL live in sub-module mem_clr_seq (ports clk, rst_n, clr_req, busy, done, idx); the array and the read/write ports stay in mem_clr_ram.

Verification
REQ-038 Release rst_n -> clr_busy=1 for 7 cycles, clr_done pulses once; reads of addresses 0..6 then return 0x00.
REQ-039 Write 0xA5 to address 3; read address 3 next cycle -> rd_data=0xA5 with rd_valid=1 one cycle after rd_en.
REQ-040 Write 0x11 to address 6 and 0x22 to address 7; read address 6 -> 0x11, read address 7 -> 0x00 (out of range, write dropped).
REQ-041 Fill all entries with 0xFF, pulse clr_req, and pulse clr_req again 3 cycles later -> one clear of exactly 7 cycles; writes during it are dropped (ready=0); all entries read 0x00.
REQ-042 Drop rst_n at clear index 4 and release -> full 7-cycle clear from index 0, a single clr_done.
REQ-043 Same-cycle write 0x3C to address 2 and read of address 2, with address 2 holding 0x10 -> rd_data=0x3C when MEM_CLR_FWD_EN is defined, 0x10 when it is undefined.

Source files
------------

// File: rtl/mem_clr_pkg.sv
// Shared types and default sizing for the self-clearing RAM.
package mem_clr_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 7;

endpackage

// File: rtl/mem_clr_seq.sv
// Clear sequencer: walks an index over 0..DEPTH-1, one entry per cycle.
// Reset parks it in CLEAR at index 0, so every reset release runs a full clear.
module mem_clr_seq
   import mem_clr_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_req,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] idx
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   clr_state_e    state_reg;
   logic [AW-1:0] idx_reg;
   logic          done_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= CLEAR;
         idx_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (clr_req) begin
                  state_reg <= CLEAR;
                  idx_reg   <= '0;
               end
            end
            CLEAR: begin
               // Wrap at DEPTH, not 2**AW: entries past DEPTH-1 do not exist.
               if (idx_reg == LAST_IDX) begin
                  state_reg <= IDLE;
                  idx_reg   <= '0;
                  done_reg  <= 1'b1;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               idx_reg   <= '0;
            end
         endcase
      end
   end

   assign busy = (state_reg == CLEAR);
   assign done = done_reg;
   assign idx  = idx_reg;

endmodule

// File: rtl/mem_clr_ram.sv
// Simple dual-port RAM with a sequential whole-array clear and registered read.
// Define MEM_CLR_FWD_EN for write-first collisions; default is read-first.
module mem_clr_ram
   import mem_clr_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_req,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic             ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             clr_busy,
   output logic             clr_done
);

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    clr_idx;
   logic             wr_ok;
   logic             rd_ok;
   logic             rd_in_range;
   logic             fwd_hit;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] rd_word;
   logic [WIDTH-1:0] rd_data_reg;
   logic             rd_valid_reg;

   mem_clr_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_seq (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_req (clr_req),
      .busy    (clr_busy),
      .done    (clr_done),
      .idx     (clr_idx)
   );

   assign ready       = ~clr_busy;
   assign wr_ok       = wr_en && ready && ({1'b0, wr_addr} < DEPTH_W);
   assign rd_ok       = rd_en && ready;
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

`ifdef MEM_CLR_FWD_EN
   assign fwd_hit = wr_ok && (wr_addr == rd_addr);
`else
   assign fwd_hit = 1'b0;
`endif

   // The clear owns the write port; user writes only land while idle.
   assign mem_we    = clr_busy | wr_ok;
   assign mem_waddr = clr_busy ? clr_idx : wr_addr;
   assign mem_wdata = clr_busy ? '0 : wr_data;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = fwd_hit ? wr_data : mem[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_ok;
         if (rd_ok) begin
            rd_data_reg <= rd_word;
         end
      end
   end

   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_mem_clr_ram.sv
// Directed bench for mem_clr_ram; reads are scored against a queue filled at issue.
module tb_mem_clr_ram;

   localparam int WIDTH = 8;
   localparam int DEPTH = 7;
   localparam int AW    = 3;

   logic             clk     = 1'b0;
   logic             rst_n   = 1'b0;
   logic             clr_req = 1'b0;
   logic             wr_en   = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             rd_en   = 1'b0;
   logic [AW-1:0]    rd_addr = '0;
   logic             ready;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             clr_busy;
   logic             clr_done;

   int vectors     = 0;
   int miscompares = 0;

   logic [WIDTH-1:0] model [8];
   logic [WIDTH-1:0] sb_q [$];
   logic [WIDTH-1:0] last_rd;
   bit               rd_expect;

   always #5 clk = ~clk;

   mem_clr_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .ready    (ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .clr_busy (clr_busy),
      .clr_done (clr_done)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: apply the driven strobes, sample 1 ns after the edge, release strobes.
   task automatic tick();
      bit               exp_v;
      logic [WIDTH-1:0] exp_d;
      exp_v = rd_expect;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         exp_v   = 1'b0;
         last_rd = '0;
      end
      check("rd_valid", {63'd0, rd_valid}, {63'd0, exp_v});
      if (exp_v) begin
         exp_d   = sb_q.pop_front();
         last_rd = exp_d;
         check("rd_data", {56'd0, rd_data}, {56'd0, exp_d});
         $display("read  data=0x%02h expected=0x%02h", rd_data, exp_d);
      end else begin
         check("rd_hold", {56'd0, rd_data}, {56'd0, last_rd});
      end
      rd_expect = 1'b0;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      clr_req   = 1'b0;
   endtask

   task automatic issue_read(input logic [AW-1:0] a, input bit accept);
      rd_en   = 1'b1;
      rd_addr = a;
      if (accept) begin
         sb_q.push_back((a < DEPTH) ? model[a] : '0);
         rd_expect = 1'b1;
      end
   endtask

   task automatic issue_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input bit accept);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      if (accept && a < DEPTH) model[a] = d;
      $display("write addr=%0d data=0x%02h", a, d);
   endtask

   // Samples busy/done starting at the first CLEAR cycle; optionally pokes the DUT mid-clear.
   task automatic wait_clear(input string tag, input bit disturb);
      int nb = 0;
      int nd = 0;
      for (int i = 0; i < 12; i++) begin
         if (clr_busy === 1'b1) nb++;
         if (clr_done === 1'b1) nd++;
         if (disturb) begin
            if (i == 1) issue_write(3'd1, 8'h77, 1'b0);
            if (i == 2) check({tag, "_ready_low"}, {63'd0, ready}, 64'd0);
            if (i == 3) clr_req = 1'b1;
            if (i == 4) issue_read(3'd2, 1'b0);
         end
         tick();
      end
      check({tag, "_busy_cycles"}, 64'(nb), 64'(DEPTH));
      check({tag, "_done_pulses"}, 64'(nd), 64'd1);
      check({tag, "_ready_after"}, {63'd0, ready}, 64'd1);
      for (int k = 0; k < 8; k++) model[k] = '0;
      $display("clear %s busy=%0d done=%0d", tag, nb, nd);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_data"},  {56'd0, rd_data},  64'd0);
      check({tag, "_rd_valid"}, {63'd0, rd_valid}, 64'd0);
      check({tag, "_clr_done"}, {63'd0, clr_done}, 64'd0);
      check({tag, "_ready"},    {63'd0, ready},    64'd0);
      check({tag, "_clr_busy"}, {63'd0, clr_busy}, 64'd1);
   endtask

   initial begin
      for (int k = 0; k < 8; k++) model[k] = '0;
      last_rd   = '0;
      rd_expect = 1'b0;

      // Reset held, then released mid-cycle: full clear and one done pulse.
      #12;
      check_reset_outputs("rst");
      tick();
      tick();
      rst_n = 1'b1;
      wait_clear("init", 1'b0);
      for (int a = 0; a < 8; a++) begin
         issue_read(3'(a), 1'b1);
         tick();
      end

      // Basic write then read.
      issue_write(3'd3, 8'hA5, 1'b1);
      tick();
      issue_read(3'd3, 1'b1);
      tick();
      tick();

      // Last in-range address and a dropped out-of-range write.
      issue_write(3'd6, 8'h11, 1'b1);
      tick();
      issue_write(3'd7, 8'h22, 1'b1);
      tick();
      issue_read(3'd6, 1'b1);
      tick();
      issue_read(3'd7, 1'b1);
      tick();

      // Fill, clear with a same-cycle write, re-request mid-clear.
      for (int a = 0; a < DEPTH; a++) begin
         issue_write(3'(a), 8'hFF, 1'b1);
         tick();
      end
      clr_req = 1'b1;
      issue_write(3'd5, 8'h55, 1'b1);
      tick();
      wait_clear("clr", 1'b1);
      for (int a = 0; a < 8; a++) begin
         issue_read(3'(a), 1'b1);
         tick();
      end

      // Reset at clear index 4 aborts; release restarts a full clear.
      issue_write(3'd6, 8'h99, 1'b1);
      tick();
      issue_read(3'd6, 1'b1);
      tick();
      clr_req = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("abort_no_done", {63'd0, clr_done}, 64'd0);
         tick();
      end
      check("abort_busy_at_idx4", {63'd0, clr_busy}, 64'd1);
      rst_n = 1'b0;
      #2;
      last_rd = '0;
      check_reset_outputs("midrst");
      tick();
      tick();
      rst_n = 1'b1;
      wait_clear("abort", 1'b0);
      issue_read(3'd6, 1'b1);
      tick();
      issue_read(3'd0, 1'b1);
      tick();

      // Same-cycle write/read collision on address 2.
      issue_write(3'd2, 8'h10, 1'b1);
      tick();
`ifdef MEM_CLR_FWD_EN
      issue_write(3'd2, 8'h3C, 1'b1);
      issue_read(3'd2, 1'b1);
`else
      issue_read(3'd2, 1'b1);
      issue_write(3'd2, 8'h3C, 1'b1);
`endif
      tick();
      issue_read(3'd2, 1'b1);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
